// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths, FSM state type and the output rounding /
//               limiting function for the symmetric FIR MAC engine.
//               Optional macro FIR_OUT_SAT_EN: saturate the scaled output
//               instead of wrapping it to DATA_WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int COEFF_WIDTH = 21;
    localparam int COEFF_FRAC  = 18;
    localparam int NUM_COEFFS  = 90;
    localparam int NUM_TAPS    = 2 * NUM_COEFFS - 1;
    localparam int ACC_WIDTH   = 46;
    // Pre-added sample (DATA_WIDTH+1) times coefficient
    localparam int PROD_WIDTH  = DATA_WIDTH + 1 + COEFF_WIDTH;
    localparam int IDX_WIDTH   = 8;
    localparam int K_WIDTH     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Half an output LSB, added before the shift for round-half-up
    localparam logic signed [ACC_WIDTH-1:0] c_round_bias =
        {{(ACC_WIDTH-COEFF_FRAC){1'b0}}, 1'b1, {(COEFF_FRAC-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] c_out_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_out_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Scale the accumulator back to sample units, then limit or wrap
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(
        input logic signed [ACC_WIDTH-1:0] acc
    );
        logic signed [ACC_WIDTH-1:0] w_rounded;
        logic signed [ACC_WIDTH-1:0] w_scaled;
        logic signed [DATA_WIDTH-1:0] w_result;
        w_rounded = acc + c_round_bias;
        w_scaled  = w_rounded >>> COEFF_FRAC;
`ifdef FIR_OUT_SAT_EN
        if (w_scaled > c_out_max) begin
            w_result = c_out_max[DATA_WIDTH-1:0];
        end else if (w_scaled < c_out_min) begin
            w_result = c_out_min[DATA_WIDTH-1:0];
        end else begin
            w_result = w_scaled[DATA_WIDTH-1:0];
        end
`else
        w_result = w_scaled[DATA_WIDTH-1:0];
`endif
        return w_result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sym_mac_preadd_mult.sv
// ============================================================================
// Module      : fir_preadd_mult
// Description : Symmetric-pair pre-adder followed by a signed multiplier,
//               with the product registered (one cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_preadd_mult
    import fir_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DATA_WIDTH-1:0]  i_sample_a,
    input  logic signed [DATA_WIDTH-1:0]  i_sample_b,
    input  logic signed [COEFF_WIDTH-1:0] i_coeff,
    output logic signed [PROD_WIDTH-1:0]  o_product
);

    logic signed [DATA_WIDTH:0]   w_preadd;
    logic signed [PROD_WIDTH-1:0] w_product_d;
    logic signed [PROD_WIDTH-1:0] r_product_q;

    // Pre-add one bit wider than a sample so the pair sum never overflows
    always_comb begin
        w_preadd    = $signed({i_sample_a[DATA_WIDTH-1], i_sample_a})
                    + $signed({i_sample_b[DATA_WIDTH-1], i_sample_b});
        w_product_d = $signed({{COEFF_WIDTH{w_preadd[DATA_WIDTH]}}, w_preadd})
                    * $signed({{(DATA_WIDTH+1){i_coeff[COEFF_WIDTH-1]}}, i_coeff});
    end

    // Product pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product_q <= '0;
        end else begin
            r_product_q <= w_product_d;
        end
    end

    assign o_product = r_product_q;

endmodule

`default_nettype wire

// File: rtl/fir_sym_mac.sv
// ============================================================================
// Module      : fir_sym_mac
// Description : Time-multiplexed 179-tap symmetric FIR. One input sample
//               starts a 90-cycle MAC pass over pre-added sample pairs, then
//               the rounded result is held on m_data until accepted.
//               Optional macro FIR_OUT_SAT_EN: saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sym_mac
    import fir_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_COEFFS*COEFF_WIDTH-1:0]   coeffs,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic signed [DATA_WIDTH-1:0]        s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic signed [DATA_WIDTH-1:0]        m_data,
    output logic                                busy
);

    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_TAPS - 1);
    localparam logic [IDX_WIDTH-1:0] c_num_taps = IDX_WIDTH'(NUM_TAPS);
    localparam logic [K_WIDTH-1:0]   c_k_centre = K_WIDTH'(NUM_COEFFS - 1);
    localparam logic [K_WIDTH-1:0]   c_k_out    = K_WIDTH'(NUM_COEFFS);

    state_t                        r_state_q, w_state_d;
    logic [K_WIDTH-1:0]            r_k_q, w_k_d;
    logic [IDX_WIDTH-1:0]          r_wptr_q, w_wptr_d;
    logic [IDX_WIDTH-1:0]          r_base_q, w_base_d;
    logic signed [ACC_WIDTH-1:0]   r_acc_q, w_acc_d;
    logic                          r_m_valid_q, w_m_valid_d;
    logic signed [DATA_WIDTH-1:0]  r_m_data_q, w_m_data_d;
    logic                          r_s_ready_q, w_s_ready_d;
    logic signed [DATA_WIDTH-1:0]  r_hist_q [NUM_TAPS];

    logic                          w_accept;
    logic [K_WIDTH-1:0]            w_k_idx;
    logic [IDX_WIDTH-1:0]          w_k_ext;
    logic [IDX_WIDTH-1:0]          w_idx_a, w_idx_b;
    logic signed [DATA_WIDTH-1:0]  w_sample_a, w_sample_b;
    logic signed [COEFF_WIDTH-1:0] w_coeff;
    logic signed [PROD_WIDTH-1:0]  w_product;
    logic signed [ACC_WIDTH-1:0]   w_acc_sum;

    // Tap addressing: x[n-k] walks back from the newest sample and
    // x[n-178+k] walks forward from the oldest, both modulo 179
    always_comb begin
        w_k_idx = (r_k_q < c_k_out) ? r_k_q : '0;
        w_k_ext = {1'b0, w_k_idx};
        if (r_base_q >= w_k_ext) begin
            w_idx_a = r_base_q - w_k_ext;
        end else begin
            w_idx_a = r_base_q + (c_num_taps - w_k_ext);
        end
        if (r_base_q >= (c_last_idx - w_k_ext)) begin
            w_idx_b = r_base_q - (c_last_idx - w_k_ext);
        end else begin
            w_idx_b = r_base_q + 8'd1 + w_k_ext;
        end
        w_sample_a = r_hist_q[w_idx_a];
        // The centre tap has no mirror partner
        w_sample_b = (w_k_idx == c_k_centre) ? '0 : r_hist_q[w_idx_b];
        w_coeff    = $signed(coeffs[w_k_idx*COEFF_WIDTH +: COEFF_WIDTH]);
    end

    fir_preadd_mult u_preadd_mult (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sample_a (w_sample_a),
        .i_sample_b (w_sample_b),
        .i_coeff    (w_coeff),
        .o_product  (w_product)
    );

    // Control: product for step k lands one cycle later, so accumulation
    // runs at k=1..89 and the k=90 cycle folds in the last product
    // directly while registering the scaled output
    always_comb begin
        w_state_d   = r_state_q;
        w_k_d       = r_k_q;
        w_wptr_d    = r_wptr_q;
        w_base_d    = r_base_q;
        w_acc_d     = r_acc_q;
        w_m_valid_d = r_m_valid_q;
        w_m_data_d  = r_m_data_q;
        w_s_ready_d = r_s_ready_q;
        w_accept    = 1'b0;
        w_acc_sum   = r_acc_q + $signed({{(ACC_WIDTH-PROD_WIDTH){w_product[PROD_WIDTH-1]}}, w_product});
        case (r_state_q)
            IDLE: begin
                w_s_ready_d = 1'b1;
                if (s_valid && r_s_ready_q) begin
                    w_accept    = 1'b1;
                    w_base_d    = r_wptr_q;
                    w_wptr_d    = (r_wptr_q == c_last_idx) ? '0 : r_wptr_q + 8'd1;
                    w_acc_d     = '0;
                    w_k_d       = '0;
                    w_s_ready_d = 1'b0;
                    w_state_d   = MAC;
                end
            end
            MAC: begin
                w_k_d = r_k_q + 7'd1;
                if (r_k_q != '0) begin
                    w_acc_d = w_acc_sum;
                end
                if (r_k_q == c_k_out) begin
                    w_m_data_d  = round_sat(w_acc_sum);
                    w_m_valid_d = 1'b1;
                    w_k_d       = '0;
                    w_state_d   = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    w_m_valid_d = 1'b0;
                    w_s_ready_d = 1'b1;
                    w_state_d   = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= IDLE;
            r_k_q       <= '0;
            r_wptr_q    <= '0;
            r_base_q    <= '0;
            r_acc_q     <= '0;
            r_m_valid_q <= 1'b0;
            r_m_data_q  <= '0;
            r_s_ready_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_k_q       <= w_k_d;
            r_wptr_q    <= w_wptr_d;
            r_base_q    <= w_base_d;
            r_acc_q     <= w_acc_d;
            r_m_valid_q <= w_m_valid_d;
            r_m_data_q  <= w_m_data_d;
            r_s_ready_q <= w_s_ready_d;
        end
    end

    // Sample history; reset wipes it so a restart begins from silence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_hist_q[i] <= '0;
            end
        end else if (w_accept) begin
            r_hist_q[r_wptr_q] <= s_data;
        end
    end

    assign s_ready = r_s_ready_q;
    assign m_valid = r_m_valid_q;
    assign m_data  = r_m_data_q;
    assign busy    = (r_state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fir_sym_mac.sv
// ============================================================================
// Module      : tb_fir_sym_mac
// Description : Self-checking bench for fir_sym_mac against a direct
//               179-tap convolution model. Honours FIR_OUT_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sym_mac;
    import fir_pkg::*;

    localparam int c_max_wait = 400;

    logic clk = 1'b0;
    logic rst_n;
    logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs;
    logic s_valid, s_ready, m_valid, m_ready, busy;
    logic signed [DATA_WIDTH-1:0] s_data, m_data;

    int errors = 0;
    int checks = 0;
    int h_m [NUM_COEFFS];
    int hist_m [$];
    int exp_q [$];
    int got_q [$];
    bit rand_stall = 1'b0;

    always #5 clk = ~clk;

    fir_sym_mac dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .coeffs  (coeffs),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .busy    (busy)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Rounded, limited or wrapped output value for a full-precision sum
    function automatic int scale(input longint acc);
        longint y;
        logic signed [DATA_WIDTH-1:0] t;
        y = (acc + (longint'(1) << (COEFF_FRAC - 1))) >>> COEFF_FRAC;
`ifdef FIR_OUT_SAT_EN
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        t = y[DATA_WIDTH-1:0];
`else
        t = y[DATA_WIDTH-1:0];
`endif
        return int'(t);
    endfunction

    // Plain convolution over the full 179-tap impulse response
    function automatic int model_push(input int x);
        longint acc;
        int tap;
        acc = 0;
        hist_m.push_front(x);
        if (hist_m.size() > NUM_TAPS) void'(hist_m.pop_back());
        for (int j = 0; j < hist_m.size(); j++) begin
            tap = (j < NUM_COEFFS) ? h_m[j] : h_m[NUM_TAPS - 1 - j];
            acc += longint'(hist_m[j]) * longint'(tap);
        end
        return scale(acc);
    endfunction

    task automatic load_coeffs();
        logic [31:0] v;
        for (int k = 0; k < NUM_COEFFS; k++) begin
            v = h_m[k];
            coeffs[k*COEFF_WIDTH +: COEFF_WIDTH] = v[COEFF_WIDTH-1:0];
        end
    endtask

    // Output compare on every cycle the output is presented
    always @(negedge clk) begin
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", 1, 0);
            end else begin
                check("out_data", int'(m_data), exp_q[0]);
            end
            if (m_ready) begin
                got_q.push_back(int'(m_data));
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end

    // Random downstream stalls
    always @(posedge clk) begin
        #1;
        if (rand_stall) m_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int x);
        int n;
        logic [31:0] v;
        n = 0;
        v = x;
        s_data  = v[DATA_WIDTH-1:0];
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < c_max_wait) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("send_timeout", 0, 1);
        else exp_q.push_back(model_push(x));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mvalid(output int cycles);
        cycles = 0;
        while (!m_valid && cycles < c_max_wait) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!m_valid) check("mvalid_timeout", 0, 1);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        check({tag, "_s_ready"}, int'(s_ready), 0);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_m_data"}, int'(m_data), 0);
        check({tag, "_busy"}, int'(busy), 0);
        hist_m.delete();
        exp_q.delete();
        got_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_impulse(input int len);
        got_q.delete();
        send(16384);
        for (int i = 1; i < len; i++) send(0);
        drain();
    endtask

    initial begin
        int cyc;
        int held;
        int expect_sat;
        logic [31:0] r;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        for (int k = 0; k < NUM_COEFFS; k++) h_m[k] = 1642 + (k * (20574 - 1642)) / 89;
        load_coeffs();
        #2;
        reset_pulse("reset");

        // Impulse response over the full span
        run_impulse(NUM_TAPS);
        check("impulse_count", got_q.size(), NUM_TAPS);
        if (got_q.size() >= NUM_TAPS) begin
            check("impulse_first", got_q[0], 103);
            check("impulse_centre", got_q[89], 1286);
            check("impulse_last", got_q[178], 103);
            foreach (got_q[k]) begin
                if (k > 0 && k < 89 && (k % 11 == 1)) check("impulse_sym", got_q[k], got_q[178 - k]);
            end
        end

        // Latency and return of s_ready
        send(1000);
        wait_mvalid(cyc);
        check("latency_mvalid", cyc, 91);
        check("latency_s_ready_out", int'(s_ready), 0);
        check("latency_busy_out", int'(busy), 1);
        @(posedge clk);
        #1;
        check("latency_s_ready_back", int'(s_ready), 1);
        check("latency_m_valid_drop", int'(m_valid), 0);
        check("latency_busy_idle", int'(busy), 0);
        drain();

        // Backpressure: output held, input ignored
        m_ready = 1'b0;
        send(-7000);
        wait_mvalid(cyc);
        held = int'(m_data);
        s_valid = 1'b1;
        s_data  = 16'sd12345;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_m_valid", int'(m_valid), 1);
            check("bp_s_ready", int'(s_ready), 0);
            check("bp_m_data_stable", int'(m_data), held);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain();
        send(3000);
        drain();

        // Reset in the middle of a MAC pass, then a clean impulse
        got_q.delete();
        send(16384);
        repeat (39) @(posedge clk);
        #3;
        reset_pulse("midmac");
        run_impulse(NUM_COEFFS);
        check("rst_impulse_count", got_q.size(), NUM_COEFFS);
        if (got_q.size() >= NUM_COEFFS) begin
            check("rst_impulse_first", got_q[0], 103);
            check("rst_impulse_centre", got_q[89], 1286);
        end

        // Full-scale gain: output limiting or wrapping
        for (int k = 0; k < NUM_COEFFS; k++) h_m[k] = 262144;
        load_coeffs();
        reset_pulse("sat");
        got_q.delete();
        for (int i = 0; i < NUM_TAPS; i++) send(32767);
        drain();
`ifdef FIR_OUT_SAT_EN
        expect_sat = 32767;
`else
        expect_sat = 32589;
`endif
        check("sat_count", got_q.size(), NUM_TAPS);
        if (got_q.size() >= NUM_TAPS) check("sat_last", got_q[178], expect_sat);

        // Random samples, moderate then full-range coefficients, random stalls
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_COEFFS; k++) begin
                if (pass == 0) h_m[k] = int'($urandom_range(0, 100000)) - 50000;
                else           h_m[k] = int'($urandom_range(0, 2097151)) - 1048576;
            end
            load_coeffs();
            rand_stall = 1'b1;
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 65535);
                send(int'(r) - 32768);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            rand_stall = 1'b0;
            m_ready = 1'b1;
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
